keccak_permute_ctrl: RTL and testbench

Sequencing controller for the Keccak state/round datapath, fed by the load stage.
- Absorb: consumes full rate blocks announced by the load stage's input-buffer handshake, absorbs each one and runs 24 permutation rounds.
- Squeeze: after the last block, releases output_size bits in rate-sized blocks, with an extra permutation between blocks.
- The input buffer is released right after absorb, so the load stage refills it while rounds run.

---
 rtl/keccak_permute_ctrl.sv | 165 ++++++++++++++++
 tb/tb_keccak_permute_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_permute_ctrl.sv
// Keccak permutation sequencer: absorbs rate blocks from the load stage,
// runs ROUNDS rounds per block and meters out rate-sized squeeze blocks.
module keccak_permute_ctrl #(
    parameter int ROUNDS        = 24,
    parameter int RATE_SHAKE128 = 1344,
    parameter int RATE_SHAKE256 = 1088
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_buffer_ready_wr,
    input  logic        last_block_in_buffer_wr,
    output logic        input_buffer_ready,
    input  logic [1:0]  operation_mode,
    input  logic [31:0] output_size,
    output logic        absorb_en,
    output logic        absorb_first,
    output logic        round_en,
    output logic [4:0]  round_idx,
    output logic        rate_sel,
    output logic        squeeze_valid,
    output logic        squeeze_last,
    input  logic        squeeze_ready,
    output logic        busy,
    output logic        done,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        PERMUTE,
        WAIT_BLOCK,
        SQUEEZE
    } state_t;

    localparam logic [31:0] RATE128 = 32'(RATE_SHAKE128);
    localparam logic [31:0] RATE256 = 32'(RATE_SHAKE256);
    localparam logic [4:0]  LAST_RND = 5'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic        last_q, last_d;
    logic        first_q, first_d;
    logic        last_abs_q, last_abs_d;
    logic [31:0] remaining_q, remaining_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        rate_sel_q, rate_sel_d;
    logic        done_q, done_d;
    logic        proto_err_q, proto_err_d;

    logic [31:0] rate;
    logic        sq_last;
    logic        wr_ok;

    assign rate    = rate_sel_q ? RATE256 : RATE128;
    assign sq_last = (remaining_q <= rate);
    assign wr_ok   = input_buffer_ready_wr & ~pending_q;

    // State register and message context, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            last_q      <= 1'b0;
            first_q     <= 1'b1;
            last_abs_q  <= 1'b0;
            remaining_q <= '0;
            cnt_q       <= '0;
            rate_sel_q  <= 1'b0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            first_q     <= first_d;
            last_abs_q  <= last_abs_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            rate_sel_q  <= rate_sel_d;
            done_q      <= done_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state and datapath strobes; a refill may land during any state.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        last_d        = last_q;
        first_d       = first_q;
        last_abs_d    = last_abs_q;
        remaining_d   = remaining_q;
        cnt_d         = cnt_q;
        rate_sel_d    = rate_sel_q;
        done_d        = 1'b0;
        proto_err_d   = proto_err_q | (input_buffer_ready_wr & pending_q);
        absorb_en     = 1'b0;
        absorb_first  = 1'b0;
        round_en      = 1'b0;
        squeeze_valid = 1'b0;

        if (wr_ok) begin
            pending_d = 1'b1;
            last_d    = last_block_in_buffer_wr;
        end

        unique case (state_q)
            IDLE, WAIT_BLOCK: begin
                if (pending_q) begin
                    absorb_en    = 1'b1;
                    absorb_first = first_q;
                    pending_d    = 1'b0;
                    state_d      = PERMUTE;
                    cnt_d        = '0;
                    last_abs_d   = last_q;
                    if (first_q) begin
                        rate_sel_d  = operation_mode[0];
                        remaining_d = output_size;
                        first_d     = 1'b0;
                    end
                end
            end
            PERMUTE: begin
                round_en = 1'b1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_RND) begin
                    cnt_d = '0;
                    if (!last_abs_q) begin
                        state_d = WAIT_BLOCK;
                    end else if (remaining_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        first_d = 1'b1;
                    end else begin
                        state_d = SQUEEZE;
                    end
                end
            end
            SQUEEZE: begin
                squeeze_valid = 1'b1;
                if (squeeze_ready) begin
                    remaining_d = (remaining_q > rate) ? remaining_q - rate : '0;
                    if (sq_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        first_d = 1'b1;
                    end else begin
                        state_d = PERMUTE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign input_buffer_ready = ~pending_q;
    assign round_idx          = cnt_q;
    assign rate_sel           = rate_sel_q;
    assign squeeze_last       = squeeze_valid & sq_last;
    assign busy               = (state_q != IDLE);
    assign done               = done_q;
    assign proto_err          = proto_err_q;

endmodule

// File: tb/tb_keccak_permute_ctrl.sv
// Bench for keccak_permute_ctrl: randomized messages checked against a
// block/round/squeeze event model plus directed corner scenarios.
module tb_keccak_permute_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_buffer_ready_wr;
    logic        last_block_in_buffer_wr;
    logic        input_buffer_ready;
    logic [1:0]  operation_mode;
    logic [31:0] output_size;
    logic        absorb_en;
    logic        absorb_first;
    logic        round_en;
    logic [4:0]  round_idx;
    logic        rate_sel;
    logic        squeeze_valid;
    logic        squeeze_last;
    logic        squeeze_ready;
    logic        busy;
    logic        done;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    keccak_permute_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .input_buffer_ready_wr   (input_buffer_ready_wr),
        .last_block_in_buffer_wr (last_block_in_buffer_wr),
        .input_buffer_ready      (input_buffer_ready),
        .operation_mode          (operation_mode),
        .output_size             (output_size),
        .absorb_en               (absorb_en),
        .absorb_first            (absorb_first),
        .round_en                (round_en),
        .round_idx               (round_idx),
        .rate_sel                (rate_sel),
        .squeeze_valid           (squeeze_valid),
        .squeeze_last            (squeeze_last),
        .squeeze_ready           (squeeze_ready),
        .busy                    (busy),
        .done                    (done),
        .proto_err               (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one message and checks every absorb/round/squeeze/done event
    // against the expected block, round and squeeze counts.
    task automatic run_msg(input int nb, input logic [1:0] mode,
                           input int osz, input int stall_n,
                           input bit ovl, input logic [1:0] ovl_mode);
        int rate, nsq, absorbs, sq, rounds, exp_idx, anchor;
        int last_r23, wcnt, budget, t, blk, exp_rounds;
        bit done_seen, prev_abs, ovl_sent;
        rate = mode[0] ? 1088 : 1344;
        nsq = (osz + rate - 1) / rate;
        exp_rounds = 24 * (nb + ((nsq > 0) ? nsq - 1 : 0));
        budget = (nb + nsq) * (30 + stall_n) + 40;
        absorbs = 0; sq = 0; rounds = 0; exp_idx = 0;
        anchor = -100; last_r23 = -100; wcnt = 0; t = 0; blk = 0;
        done_seen = 0; prev_abs = 0; ovl_sent = 0;
        operation_mode = mode;
        output_size = 32'(osz);
        while (!done_seen && t < budget) begin
            if (prev_abs) begin
                checks++;
                if (input_buffer_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ibr_after_absorb t=%0d got=%b want=1",
                             t, input_buffer_ready);
                end
            end
            prev_abs = absorb_en;
            if (done) begin
                done_seen = 1;
                checks++;
                if (absorbs != nb || sq != nsq || rounds != exp_rounds) begin
                    errors++;
                    $display("FAIL done_counts abs=%0d sq=%0d rnd=%0d want %0d %0d %0d",
                             absorbs, sq, rounds, nb, nsq, exp_rounds);
                end
                checks++;
                if (t != anchor + 1 || busy !== 1'b0 || proto_err !== 1'b0) begin
                    errors++;
                    $display("FAIL done_timing t=%0d anchor=%0d busy=%b perr=%b want t=anchor+1 busy=0 perr=0",
                             t, anchor, busy, proto_err);
                end
            end else begin
                if (absorb_en) begin
                    checks++;
                    if (absorbs >= nb || absorb_first !== (absorbs == 0) ||
                        round_en !== 1'b0) begin
                        errors++;
                        $display("FAIL absorb n=%0d first=%b round_en=%b want n<%0d first=%b",
                                 absorbs, absorb_first, round_en, nb, absorbs == 0);
                    end
                    checks++;
                    if (t != ((absorbs == 0) ? 1 : last_r23 + 1)) begin
                        errors++;
                        $display("FAIL absorb_time t=%0d want %0d",
                                 t, (absorbs == 0) ? 1 : last_r23 + 1);
                    end
                    absorbs++;
                    anchor = t;
                    exp_idx = 0;
                end
                if (round_en) begin
                    checks++;
                    if (int'(round_idx) != exp_idx || t != anchor + 1 || absorbs == 0) begin
                        errors++;
                        $display("FAIL round t=%0d idx=%0d want idx=%0d t=%0d",
                                 t, round_idx, exp_idx, anchor + 1);
                    end
                    if (round_idx == 5'd23) last_r23 = t;
                    exp_idx++;
                    anchor = t;
                    rounds++;
                end
                if (squeeze_valid) begin
                    checks++;
                    if (sq >= nsq || squeeze_last !== (sq == nsq - 1) ||
                        rate_sel !== mode[0] || round_en !== 1'b0 || absorbs != nb) begin
                        errors++;
                        $display("FAIL squeeze blk=%0d last=%b rsel=%b rnd=%b want blk<%0d last=%b rsel=%b",
                                 sq, squeeze_last, rate_sel, round_en, nsq,
                                 sq == nsq - 1, mode[0]);
                    end
                    if (wcnt == 0) begin
                        checks++;
                        if (t != last_r23 + 1) begin
                            errors++;
                            $display("FAIL squeeze_time t=%0d want %0d", t, last_r23 + 1);
                        end
                    end
                end
            end
            if (!done_seen) begin
                input_buffer_ready_wr = 1'b0;
                last_block_in_buffer_wr = 1'b0;
                if (input_buffer_ready && blk < nb) begin
                    input_buffer_ready_wr = 1'b1;
                    last_block_in_buffer_wr = (blk == nb - 1);
                    blk++;
                end else if (ovl && !ovl_sent && squeeze_valid && input_buffer_ready) begin
                    input_buffer_ready_wr = 1'b1;
                    last_block_in_buffer_wr = 1'b1;
                    ovl_sent = 1;
                    operation_mode = ovl_mode;
                    output_size = 32'd0;
                end
                squeeze_ready = squeeze_valid && (wcnt >= stall_n);
                if (squeeze_valid) begin
                    if (squeeze_ready) begin
                        sq++;
                        anchor = t;
                        exp_idx = 0;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
                tick();
                t++;
            end
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL msg_timeout budget=%0d cycles got no done", budget);
        end
        input_buffer_ready_wr = 1'b0;
        last_block_in_buffer_wr = 1'b0;
        squeeze_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        input_buffer_ready_wr = 1'b0;
        last_block_in_buffer_wr = 1'b0;
        operation_mode = 2'b00;
        output_size = 32'd0;
        squeeze_ready = 1'b0;
        repeat (2) tick();
        checks++;
        if ({input_buffer_ready, absorb_en, absorb_first, round_en, round_idx,
             rate_sel, squeeze_valid, squeeze_last, busy, done, proto_err}
            !== 15'b100000000000000) begin
            errors++;
            $display("FAIL reset_outputs ibr=%b abs=%b rnd=%b idx=%0d busy=%b perr=%b want ibr=1 rest 0",
                     input_buffer_ready, absorb_en, round_en, round_idx, busy, proto_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        run_msg(1, 2'b00, 256, 1, 0, 2'b00);
    endtask

    task automatic test_multi_block();
        run_msg(3, 2'b01, 500, 0, 0, 2'b00);
    endtask

    task automatic test_long_squeeze();
        run_msg(1, 2'b00, 3000, 0, 0, 2'b00);
    endtask

    task automatic test_stall();
        run_msg(1, 2'b11, 2000, 10, 0, 2'b00);
    endtask

    task automatic test_zero_output();
        run_msg(2, 2'b00, 0, 0, 0, 2'b00);
    endtask

    // Next message's first block arrives during squeeze; absorbed only in IDLE.
    task automatic test_overlap();
        bit got_done;
        bit saw_sq;
        run_msg(1, 2'b00, 2000, 2, 1, 2'b01);
        checks++;
        if (absorb_en !== 1'b1 || absorb_first !== 1'b1) begin
            errors++;
            $display("FAIL overlap_absorb abs=%b first=%b want 1 1", absorb_en, absorb_first);
        end
        tick();
        checks++;
        if (round_en !== 1'b1 || round_idx !== 5'd0 || rate_sel !== 1'b1) begin
            errors++;
            $display("FAIL overlap_start rnd=%b idx=%0d rsel=%b want 1 0 1",
                     round_en, round_idx, rate_sel);
        end
        got_done = 0;
        saw_sq = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (squeeze_valid) saw_sq = 1;
            if (done) got_done = 1;
            else tick();
        end
        checks++;
        if (!got_done || saw_sq) begin
            errors++;
            $display("FAIL overlap_zero done=%b squeeze_seen=%b want 1 0", got_done, saw_sq);
        end
        tick();
    endtask

    task automatic test_random();
        for (int m = 0; m < 12; m++) begin
            run_msg(int'($urandom_range(1, 3)), 2'($urandom),
                    int'($urandom_range(0, 4500)), int'($urandom_range(0, 3)),
                    0, 2'b00);
            tick();
        end
    endtask

    // Second write while a block is pending is dropped and flagged sticky.
    task automatic test_proto_err();
        int absorbs;
        bit got_done;
        operation_mode = 2'b00;
        output_size = 32'd0;
        input_buffer_ready_wr = 1'b1;
        last_block_in_buffer_wr = 1'b0;
        tick();
        input_buffer_ready_wr = 1'b0;
        absorbs = 0;
        got_done = 0;
        for (int t = 1; t < 200 && !got_done; t++) begin
            if (absorb_en) absorbs++;
            if (done) got_done = 1;
            input_buffer_ready_wr = 1'b0;
            last_block_in_buffer_wr = 1'b0;
            if (round_en && absorbs == 1 && round_idx == 5'd3) begin
                input_buffer_ready_wr = 1'b1;
                last_block_in_buffer_wr = 1'b1;
            end
            if (round_en && absorbs == 1 && round_idx == 5'd5) begin
                input_buffer_ready_wr = 1'b1;
                last_block_in_buffer_wr = 1'b0;
            end
            tick();
        end
        input_buffer_ready_wr = 1'b0;
        checks++;
        if (!got_done || absorbs != 2) begin
            errors++;
            $display("FAIL perr_blocks done=%b absorbs=%0d want 1 2", got_done, absorbs);
        end
        repeat (3) tick();
        checks++;
        if (proto_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL perr_sticky perr=%b busy=%b want 1 0", proto_err, busy);
        end
    endtask

    // Async reset mid-permutation with a pending block and a raised error.
    task automatic test_reset_mid();
        bit hit;
        operation_mode = 2'b01;
        output_size = 32'd5000;
        input_buffer_ready_wr = 1'b1;
        last_block_in_buffer_wr = 1'b1;
        tick();
        input_buffer_ready_wr = 1'b0;
        hit = 0;
        for (int t = 0; t < 40 && !hit; t++) begin
            input_buffer_ready_wr = round_en && (round_idx == 5'd2 || round_idx == 5'd4);
            if (round_en && round_idx == 5'd12) hit = 1;
            else tick();
        end
        input_buffer_ready_wr = 1'b0;
        checks++;
        if (!hit || proto_err !== 1'b1 || input_buffer_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_setup hit=%b perr=%b ibr=%b want 1 1 0",
                     hit, proto_err, input_buffer_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({input_buffer_ready, absorb_en, absorb_first, round_en, round_idx,
             rate_sel, squeeze_valid, squeeze_last, busy, done, proto_err}
            !== 15'b100000000000000) begin
            errors++;
            $display("FAIL rstmid_outputs ibr=%b rnd=%b idx=%0d rsel=%b busy=%b perr=%b want ibr=1 rest 0",
                     input_buffer_ready, round_en, round_idx, rate_sel, busy, proto_err);
        end
        tick();
        rst = 1'b0;
        tick();
        run_msg(1, 2'b00, 1344, 0, 0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_multi_block();
        tick();
        test_long_squeeze();
        tick();
        test_stall();
        tick();
        test_zero_output();
        tick();
        test_overlap();
        test_random();
        test_proto_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
